pix_mem_arbiter: RTL

Arbitrates a single-port synchronous pixel SRAM between two requesters: the video line fetcher (read port, latency-critical) and the Nios-driven pixel writer fed from the 24-bit bmp_pixout path (write port, buffered). Reads have fixed priority. Writes are queued in a small FIFO, and a starvation guard forces one write slot after a bounded wait. The block sits between the nios_system pixel export, the VGA fetch logic and the on-board pixel memory, and is the only master of that memory.

---
 rtl/pix_mem_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pix_mem_arbiter.sv
// Single-port pixel SRAM arbiter: fixed-priority video reads, FIFO-buffered
// pixel writes, and a starvation guard that forces one write slot.
module pix_mem_arbiter #(
   parameter int unsigned ADDR_W        = 19,
   parameter int unsigned DATA_W        = 24,
   parameter int unsigned WR_FIFO_DEPTH = 4,
   parameter int unsigned STARVE_LIMIT  = 8
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              wr_idle,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned PTR_W = (WR_FIFO_DEPTH > 1) ? $clog2(WR_FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(WR_FIFO_DEPTH + 1);
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WR_FIFO_DEPTH);
   localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      GNT_IDLE,
      GNT_READ,
      GNT_WRITE
   } gnt_e;

   logic [ADDR_W-1:0] r_fifo_addr [WR_FIFO_DEPTH];
   logic [DATA_W-1:0] r_fifo_data [WR_FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  w_count_nxt;
   logic              r_wr_ready;
   logic [STV_W-1:0]  r_starve;
   logic [STV_W-1:0]  w_starve_nxt;
   logic              r_rd_capture;
   logic              r_rd_valid;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   gnt_e              w_gnt;
   logic              w_fifo_ne;
   logic              w_force;
   logic              w_push;
   logic              w_pop;
   logic              w_rd_issue;

   assign w_fifo_ne  = (r_count != '0);
   assign w_force    = w_fifo_ne && (r_starve == LIMIT_C);
   assign w_push     = wr_valid && r_wr_ready;
   assign w_pop      = (w_gnt == GNT_WRITE);
   assign w_rd_issue = r_mem_en && !r_mem_we;

   // Forced write outranks reads; otherwise reads win and writes fill the gaps.
   always_comb begin
      w_gnt = GNT_IDLE;
      if (w_force) begin
         w_gnt = GNT_WRITE;
      end else if (rd_req) begin
         w_gnt = GNT_READ;
      end else if (w_fifo_ne) begin
         w_gnt = GNT_WRITE;
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_comb begin
      w_starve_nxt = r_starve;
      if (!w_fifo_ne || w_pop) begin
         w_starve_nxt = '0;
      end else if ((w_gnt == GNT_READ) && (r_starve != LIMIT_C)) begin
         w_starve_nxt = r_starve + STV_W'(1);
      end
   end

   always_ff @(posedge clk_clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= wr_addr;
         r_fifo_data[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_wr_ready <= 1'b1;
         r_starve   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count    <= w_count_nxt;
         r_wr_ready <= (w_count_nxt < DEPTH_C);
         r_starve   <= w_starve_nxt;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (w_gnt)
            GNT_READ: begin
               r_mem_en   <= 1'b1;
               r_mem_we   <= 1'b0;
               r_mem_addr <= rd_addr;
            end
            GNT_WRITE: begin
               r_mem_en    <= 1'b1;
               r_mem_we    <= 1'b1;
               r_mem_addr  <= r_fifo_addr[r_rd_ptr];
               r_mem_wdata <= r_fifo_data[r_rd_ptr];
            end
            default: begin
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
            end
         endcase
      end
   end

   // SRAM data is valid the cycle after issue; it is captured only then.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_rd_capture <= 1'b0;
         r_rd_valid   <= 1'b0;
         r_rd_data    <= '0;
      end else begin
         r_rd_capture <= w_rd_issue;
         r_rd_valid   <= r_rd_capture;
         if (r_rd_capture) r_rd_data <= mem_rdata;
      end
   end

   assign rd_gnt    = (w_gnt == GNT_READ);
   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;
   assign wr_ready  = r_wr_ready;
   assign wr_idle   = !w_fifo_ne && !(r_mem_en && r_mem_we);
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   a_no_overflow: assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
      !(w_push && !w_pop && (r_count == DEPTH_C)));
   a_no_underflow: assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
      !(w_pop && (r_count == '0)));

endmodule
